// File: rtl/spi_bus_pkg.sv
// Shared types and constants for the SPI bus arbiter and the security logic around it.
package spi_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO,
        CAPTURE,
        GAP,
        DONE,
        ABORT
    } arb_state_t;

    // Command bytes understood by the Arduino soft slave.
    localparam logic [7:0] CMD_UID              = 8'hAA;
    localparam logic [7:0] CMD_STATE_DISENGAGED = 8'hBA;
    localparam logic [7:0] CMD_STATE_BB         = 8'hBB;
    localparam logic [7:0] CMD_STATE_BC         = 8'hBC;
    localparam logic [7:0] CMD_STATE_BD         = 8'hBD;

    localparam logic [31:0] UID_AUTH_0 = 32'h332C1EB7;
    localparam logic [31:0] UID_AUTH_1 = 32'h336BF410;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after rr_ptr, with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets 1..NUM_REQ so the previous winner is considered last.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid            = 1'b1;
                pick_onehot[cand_idx] = 1'b1;
                pick_idx              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one 8-bit SPI master between several frame requesters, running one
// multi-byte frame at a time with an inter-byte gap and a busy timeout.
module spi_bus_arbiter
    import spi_bus_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int MAX_BYTES      = 5,
    parameter int GAP_CYCLES     = 500000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*3-1:0]            req_len,
    input  logic [NUM_REQ*8*MAX_BYTES-1:0]  req_tx,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            error,
    output logic [8*MAX_BYTES-1:0]          rx_data,
    output logic                            spi_start_n,
    output logic [7:0]                      spi_data_in,
    input  logic                            spi_busy,
    input  logic [7:0]                      spi_data_out
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int LEN_W   = $clog2(MAX_BYTES + 1);
    localparam int FRAME_W = 8 * MAX_BYTES;
    localparam int CNT_W   = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [LEN_W-1:0]   frame_len;
    logic [LEN_W-1:0]   byte_idx;
    logic [FRAME_W-1:0] tx_buf;
    logic [CNT_W-1:0]   timer;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [2:0]         raw_len;
    logic [LEN_W-1:0]   clamp_len;
    logic [FRAME_W-1:0] sel_tx;
    logic [7:0]         tx_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    // Length and payload of the requester the arbiter is picking this cycle.
    always_comb begin
        raw_len = '0;
        sel_tx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                raw_len = req_len[i*3 +: 3];
                sel_tx  = req_tx[i*FRAME_W +: FRAME_W];
            end
        end
        if (raw_len == 3'd0) begin
            clamp_len = LEN_W'(1);
        end else if (int'(raw_len) > MAX_BYTES) begin
            clamp_len = LEN_W'(MAX_BYTES);
        end else begin
            clamp_len = LEN_W'(raw_len);
        end
    end

    always_comb begin
        tx_byte = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (byte_idx == LEN_W'(k)) begin
                tx_byte = tx_buf[(MAX_BYTES-1-k)*8 +: 8];
            end
        end
    end

    // Frame sequencer; done/error/spi_start_n default to their idle level each cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            grant       <= '0;
            done        <= '0;
            error       <= 1'b0;
            rx_data     <= '0;
            spi_start_n <= 1'b1;
            spi_data_in <= '0;
            frame_len   <= '0;
            byte_idx    <= '0;
            tx_buf      <= '0;
            timer       <= '0;
        end else begin
            done        <= '0;
            error       <= 1'b0;
            spi_start_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (pick_valid) begin
                        grant     <= pick_onehot;
                        rr_ptr    <= pick_idx;
                        frame_len <= clamp_len;
                        tx_buf    <= sel_tx;
                        rx_data   <= '0;
                        byte_idx  <= '0;
                        state     <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    spi_data_in <= tx_byte;
                    spi_start_n <= 1'b0;
                    state       <= START;
                end
                START: begin
                    timer <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (spi_busy) begin
                        timer <= '0;
                        state <= WAIT_LO;
                    end else if (timer == TIMEOUT_LAST) begin
                        done  <= grant;
                        error <= 1'b1;
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!spi_busy) begin
                        state <= CAPTURE;
                    end else if (timer == TIMEOUT_LAST) begin
                        done  <= grant;
                        error <= 1'b1;
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < MAX_BYTES; k++) begin
                        if (byte_idx == LEN_W'(k) && byte_idx < frame_len) begin
                            rx_data[(MAX_BYTES-1-k)*8 +: 8] <= spi_data_out;
                        end
                    end
                    byte_idx <= byte_idx + 1'b1;
                    timer    <= '0;
                    state    <= GAP;
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        if (byte_idx == frame_len) begin
                            done  <= grant;
                            state <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE, ABORT: begin
                    grant <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a behavioural SPI master stub.
module tb_spi_bus_arbiter;
    import spi_bus_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int MAX_BYTES = 5;
    localparam int GAP       = 8;
    localparam int TIMEOUT   = 20;

    logic                           CLOCK_50;
    logic                           reset;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*3-1:0]           req_len;
    logic [NUM_REQ*8*MAX_BYTES-1:0] req_tx;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             done;
    logic                           error;
    logic [8*MAX_BYTES-1:0]         rx_data;
    logic                           spi_start_n;
    logic [7:0]                     spi_data_in;
    logic                           spi_busy;
    logic [7:0]                     spi_data_out;

    int         vectors;
    int         miscompares;
    int         cyc;
    int         stub_total;
    int         resp_base;
    int         stub_mode;
    logic [7:0] resp [5];
    logic [7:0] log_data [64];
    int         log_cyc [64];

    spi_bus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .MAX_BYTES      (MAX_BYTES),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .req          (req),
        .req_len      (req_len),
        .req_tx       (req_tx),
        .grant        (grant),
        .done         (done),
        .error        (error),
        .rx_data      (rx_data),
        .spi_start_n  (spi_start_n),
        .spi_data_in  (spi_data_in),
        .spi_busy     (spi_busy),
        .spi_data_out (spi_data_out)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLOCK_50);
            cyc++;
        end
    end

    // Stub master: busy rises one cycle after a start pulse and stays high four cycles.
    initial begin : stub
        int k;
        spi_busy     = 1'b0;
        spi_data_out = 8'h00;
        stub_total   = 0;
        forever begin
            @(negedge CLOCK_50);
            if (!reset && spi_start_n === 1'b0) begin
                if (stub_total < 64) begin
                    log_data[stub_total] = spi_data_in;
                    log_cyc[stub_total]  = cyc;
                end
                k = stub_total - resp_base;
                stub_total++;
                if (stub_mode == 0) begin
                    @(negedge CLOCK_50);
                    spi_busy     = 1'b1;
                    spi_data_out = (k >= 0 && k < 5) ? resp[k] : 8'hEE;
                    repeat (4) @(negedge CLOCK_50);
                    spi_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [2:0] l0, input logic [2:0] l1,
                                 input logic [39:0] t0, input logic [39:0] t1);
        req     = r;
        req_len = {l1, l0};
        req_tx  = {t1, t0};
    endtask

    task automatic waitDone(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (done == '0 && n < bound);
    endtask

    task automatic waitGrant(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (grant == '0 && n < bound);
    endtask

    task automatic waitStarts(input int target, input int bound);
        int n;
        n = 0;
        while (stub_total < target && n < bound) begin
            @(negedge CLOCK_50);
            n++;
        end
    endtask

    initial begin
        int         b;
        int         t_done;
        logic [39:0] exp_tx;
        vectors     = 0;
        miscompares = 0;
        resp_base   = 0;
        stub_mode   = 0;
        resp        = '{8'h5A, 8'h33, 8'h2C, 8'h1E, 8'hB7};
        reset       = 1'b1;
        applyStimulus(2'b00, 3'd0, 3'd0, 40'h0, 40'h0);

        @(negedge CLOCK_50);
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_done", done, 2'b00);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_rx", rx_data, 40'h0);
        checkOutput("rst_start_n", spi_start_n, 1'b1);
        checkOutput("rst_data_in", spi_data_in, 8'h00);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);

        $display("[TB] single UID frame");
        b      = stub_total;
        resp_base = b;
        exp_tx = {CMD_UID, 32'h0};
        applyStimulus(2'b01, 3'd5, 3'd1, exp_tx, 40'h0);
        repeat (3) @(negedge CLOCK_50);
        checkOutput("uid_latency_start_n", spi_start_n, 1'b0);
        checkOutput("uid_latency_grant", grant, 2'b01);
        checkOutput("uid_first_byte", spi_data_in, CMD_UID);
        waitDone(400);
        checkOutput("uid_done", done, 2'b01);
        checkOutput("uid_error", error, 1'b0);
        checkOutput("uid_rx", rx_data, {8'h5A, UID_AUTH_0});
        applyStimulus(2'b00, 3'd5, 3'd1, exp_tx, 40'h0);
        checkOutput("uid_start_count", stub_total - b, 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("uid_tx%0d", i), log_data[b+i], exp_tx[(4-i)*8 +: 8]);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("uid_gap%0d", i), log_cyc[b+i+1] - log_cyc[b+i], GAP + 8);
        end
        @(negedge CLOCK_50);
        checkOutput("uid_done_pulse", done, 2'b00);
        checkOutput("uid_grant_drop", grant, 2'b00);

        $display("[TB] contention");
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        applyStimulus(2'b11, 3'd1, 3'd1, {CMD_STATE_DISENGAGED, 32'h0}, {CMD_STATE_BB, 32'h0});
        waitGrant(10);
        checkOutput("cont_first", grant, 2'b01);
        waitDone(200);
        checkOutput("cont_first_done", done, 2'b01);
        waitGrant(10);
        checkOutput("cont_second", grant, 2'b10);
        waitDone(200);
        checkOutput("cont_second_done", done, 2'b10);
        req = 2'b00;
        repeat (2) @(negedge CLOCK_50);
        req = 2'b11;
        waitGrant(10);
        checkOutput("cont_wrap", grant, 2'b01);
        waitDone(200);
        checkOutput("cont_wrap_done", done, 2'b01);
        req = 2'b00;
        repeat (2) @(negedge CLOCK_50);
        req = 2'b11;
        waitGrant(10);
        checkOutput("cont_after_req0", grant, 2'b10);
        waitDone(200);
        checkOutput("cont_after_req0_done", done, 2'b10);
        req = 2'b00;
        repeat (2) @(negedge CLOCK_50);

        $display("[TB] busy timeout");
        stub_mode = 1;
        b         = stub_total;
        resp_base = b;
        applyStimulus(2'b01, 3'd2, 3'd1, {CMD_UID, 32'h0}, 40'h0);
        waitDone(TIMEOUT + 40);
        t_done = cyc;
        checkOutput("to_done", done, 2'b01);
        checkOutput("to_error", error, 1'b1);
        checkOutput("to_start_n", spi_start_n, 1'b1);
        checkOutput("to_rx", rx_data, 40'h0);
        checkOutput("to_latency", t_done - log_cyc[b], TIMEOUT + 1);
        req = 2'b00;
        @(negedge CLOCK_50);
        checkOutput("to_grant_drop", grant, 2'b00);
        checkOutput("to_error_pulse", error, 1'b0);
        stub_mode = 0;
        repeat (2) @(negedge CLOCK_50);

        $display("[TB] reset mid-frame");
        b         = stub_total;
        resp_base = b;
        exp_tx    = 40'hAA_11_22_33_44;
        applyStimulus(2'b01, 3'd5, 3'd1, exp_tx, 40'h0);
        waitStarts(b + 3, 300);
        for (int n = 0; n < 20 && spi_busy !== 1'b1; n++) begin
            @(negedge CLOCK_50);
        end
        @(negedge CLOCK_50);
        checkOutput("mid_grant_before", grant, 2'b01);
        reset = 1'b1;
        #1;
        checkOutput("mid_grant", grant, 2'b00);
        checkOutput("mid_done", done, 2'b00);
        checkOutput("mid_error", error, 1'b0);
        checkOutput("mid_rx", rx_data, 40'h0);
        checkOutput("mid_start_n", spi_start_n, 1'b1);
        checkOutput("mid_data_in", spi_data_in, 8'h00);
        for (int n = 0; n < 3; n++) begin
            @(negedge CLOCK_50);
            checkOutput($sformatf("mid_no_done%0d", n), done, 2'b00);
        end
        reset     = 1'b0;
        b         = stub_total;
        resp_base = b;
        waitStarts(b + 1, 20);
        checkOutput("mid_restart_byte0", log_data[b], 8'hAA);
        waitDone(400);
        checkOutput("mid_restart_done", done, 2'b01);
        checkOutput("mid_restart_error", error, 1'b0);
        checkOutput("mid_restart_rx", rx_data, {8'h5A, UID_AUTH_0});
        checkOutput("mid_restart_count", stub_total - b, 5);
        req = 2'b00;
        repeat (2) @(negedge CLOCK_50);

        $display("[TB] request dropped mid-frame");
        b         = stub_total;
        resp_base = b;
        applyStimulus(2'b10, 3'd1, 3'd1, 40'h0, {CMD_STATE_BB, 32'h0});
        repeat (3) @(negedge CLOCK_50);
        checkOutput("drop_start_n", spi_start_n, 1'b0);
        checkOutput("drop_grant", grant, 2'b10);
        checkOutput("drop_byte", spi_data_in, CMD_STATE_BB);
        @(negedge CLOCK_50);
        req = 2'b00;
        waitDone(200);
        checkOutput("drop_done", done, 2'b10);
        checkOutput("drop_error", error, 1'b0);
        checkOutput("drop_rx", rx_data, {8'h5A, 32'h0});
        repeat (15) @(negedge CLOCK_50);
        checkOutput("drop_no_regrant", grant, 2'b00);

        $display("[TB] zero length clamps to one byte");
        b         = stub_total;
        resp_base = b;
        applyStimulus(2'b01, 3'd0, 3'd1, {CMD_STATE_BC, 32'h11223344}, 40'h0);
        waitDone(200);
        checkOutput("len0_done", done, 2'b01);
        checkOutput("len0_error", error, 1'b0);
        checkOutput("len0_rx", rx_data, {8'h5A, 32'h0});
        checkOutput("len0_count", stub_total - b, 1);
        checkOutput("len0_byte", log_data[b], CMD_STATE_BC);
        req = 2'b00;
        repeat (2) @(negedge CLOCK_50);

        $display("[TB] oversize length clamps to MAX_BYTES");
        b         = stub_total;
        resp_base = b;
        applyStimulus(2'b01, 3'd7, 3'd1, 40'hAA_01_02_03_04, 40'h0);
        waitDone(400);
        checkOutput("len7_done", done, 2'b01);
        checkOutput("len7_count", stub_total - b, 5);
        checkOutput("len7_rx", rx_data, {8'h5A, UID_AUTH_0});
        req = 2'b00;
        repeat (2) @(negedge CLOCK_50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
